// File: rtl/key_disp_pkg.sv
// Shared constants for the key/display controller: mode encodings and 7-segment patterns.
// Segment bit order is {a,b,c,d,e,f,g}, active high.
package key_disp_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] MODE_MANUAL = 2'd0;
    localparam logic [1:0] MODE_RUN    = 2'd1;
    localparam logic [1:0] MODE_PAUSE  = 2'd2;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal codes light nothing rather than showing a misleading glyph.
    function automatic logic [6:0] seg_decode(input bcd_t bcd);
        logic [6:0] pattern;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// One registered BCD digit of the ripple up/down counter.
// cin/bin are the carry/borrow requests from the next-lower digit (tied high for the units digit).
module bcd_updown_digit
    import key_disp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic up,
    input  logic down,
    input  logic cin,
    input  logic bin,
    output bcd_t q,
    output logic cout,
    output logic bout
);

    bcd_t eff;
    logic step_up;
    logic step_down;

    // A corrupted code (10..15) is treated as zero on its next update.
    assign eff       = (q > 4'd9) ? 4'd0 : q;
    assign step_up   = up & cin & ~down;
    assign step_down = down & bin & ~up;
    assign cout      = step_up & (eff == 4'd9);
    assign bout      = step_down & (eff == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (step_up) begin
            q <= (eff == 4'd9) ? 4'd0 : eff + 4'd1;
        end else if (step_down) begin
            q <= (eff == 4'd0) ? 4'd9 : eff - 4'd1;
        end
    end

endmodule

// File: rtl/key_disp_ctrl.sv
// Key-driven 4-digit BCD up/down counter with manual/run/pause modes,
// time-multiplexed onto a single common 7-segment display with leading-zero blanking.
module key_disp_ctrl
    import key_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int AUTO_DIV = 50000000,
    parameter int DIGITS   = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_flag,
    input  logic              dec_flag,
    input  logic              mode_flag,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_sel,
    output logic              co,
    output logic [1:0]        mode
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [1:0]        mode_next;
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_tick;
    logic              count_up;
    logic              count_down;

    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  scan_idx_next;

    bcd_t              digit_q [DIGITS];
    logic [DIGITS:0]   carry_chain;
    logic [DIGITS:0]   borrow_chain;
    logic [DIGITS-1:0] blank;
    logic [6:0]        seg_next;

    // Mode FSM: the unused encoding falls back to MANUAL on the next clock.
    always_comb begin
        mode_next = mode;
        case (mode)
            MODE_MANUAL: if (mode_flag) mode_next = MODE_RUN;
            MODE_RUN:    if (mode_flag) mode_next = MODE_PAUSE;
            MODE_PAUSE:  if (mode_flag) mode_next = MODE_MANUAL;
            default:     mode_next = MODE_MANUAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= MODE_MANUAL;
        end else begin
            mode <= mode_next;
        end
    end

    assign auto_tick = (mode == MODE_RUN) && (auto_cnt == AUTO_LAST);

    // Entering RUN restarts the step period; PAUSE simply freezes the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (mode_flag) begin
            if (mode_next == MODE_RUN) begin
                auto_cnt <= '0;
            end
        end else if (mode == MODE_RUN) begin
            auto_cnt <= auto_tick ? '0 : auto_cnt + 1'b1;
        end
    end

    // A mode press in the same cycle swallows any count event.
    assign count_up   = ~mode_flag &
                        (((mode == MODE_MANUAL) & inc_flag & ~dec_flag) | auto_tick);
    assign count_down = ~mode_flag & (mode == MODE_MANUAL) & dec_flag & ~inc_flag;

    assign carry_chain[0]  = 1'b1;
    assign borrow_chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_updown_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .up    (count_up),
            .down  (count_down),
            .cin   (carry_chain[g]),
            .bin   (borrow_chain[g]),
            .q     (digit_q[g]),
            .cout  (carry_chain[g+1]),
            .bout  (borrow_chain[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            co <= 1'b0;
        end else begin
            co <= carry_chain[DIGITS];
        end
    end

    assign scan_idx_next = (scan_cnt != SCAN_LAST) ? scan_idx :
                           (scan_idx == IDX_LAST)  ? '0 : scan_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
            scan_idx <= scan_idx_next;
        end
    end

    // A digit is blank when it and every higher digit are zero; units always show.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        blank       = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            higher_zero = higher_zero & (digit_q[k] == 4'd0);
            blank[k]    = (k != 0) & higher_zero;
        end
    end

    assign seg_next = blank[scan_idx_next] ? SEG_BLANK : seg_decode(digit_q[scan_idx_next]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sel <= ~DIGITS'(1);
            seg     <= SEG_0;
        end else begin
            dig_sel <= ~(DIGITS'(1) << scan_idx_next);
            seg     <= seg_next;
        end
    end

endmodule

// File: tb/tb_key_disp_ctrl.sv
// Randomised and directed bench for key_disp_ctrl, checked every cycle against a
// value-level model (decimal integer, mode number, time-derived scan slot).
module tb_key_disp_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       inc_flag  = 1'b0;
    logic       dec_flag  = 1'b0;
    logic       mode_flag = 1'b0;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic       co;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: counter as a plain integer 0..9999 and the value before the last edge.
    int m_val   = 0;
    int m_prev  = 0;
    int m_mode  = 0;
    int m_phase = 0;
    int m_cyc   = 0;
    bit m_co    = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    key_disp_ctrl #(.SCAN_DIV(4), .AUTO_DIV(16), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_flag  (inc_flag),
        .dec_flag  (dec_flag),
        .mode_flag (mode_flag),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .co        (co),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0b required=%0b at %0t", name, actual, required, $time);
        end
    endtask

    task automatic applyStimulus(input bit inc, input bit dec, input bit modef);
        inc_flag  = inc;
        dec_flag  = dec;
        mode_flag = modef;
        @(posedge clk);
        #1;
        inc_flag  = 1'b0;
        dec_flag  = 1'b0;
        mode_flag = 1'b0;
    endtask

    task automatic wait_slot(input logic [3:0] want, input string name, input logic [6:0] exp_seg);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dig_sel == want) found = 1'b1;
        end
        checkOutput({name, "_slot_reached"}, 32'(found), 32'd1);
        if (found) checkOutput(name, 32'(seg), 32'(exp_seg));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_dig_sel", 32'(dig_sel), 32'b1110);
        checkOutput("rst_seg", 32'(seg), 32'b1111110);
        checkOutput("rst_mode", 32'(mode), 32'd0);
        checkOutput("rst_co", 32'(co), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0; m_prev = 0; m_mode = 0; m_phase = 0; m_cyc = 0; m_co = 1'b0;
        end else begin
            m_prev = m_val;
            m_co   = 1'b0;
            m_cyc++;
            if (mode_flag) begin
                m_mode = (m_mode + 1) % 3;
                if (m_mode == 1) m_phase = 0;
            end else if (m_mode == 0) begin
                if (inc_flag && !dec_flag) begin
                    m_co  = (m_val == 9999);
                    m_val = (m_val + 1) % 10000;
                end else if (dec_flag && !inc_flag) begin
                    m_val = (m_val + 9999) % 10000;
                end
            end else if (m_mode == 1) begin
                m_phase++;
                if (m_phase == 16) begin
                    m_phase = 0;
                    m_co  = (m_val == 9999);
                    m_val = (m_val + 1) % 10000;
                end
            end
        end
    end

    // Slot index follows purely from elapsed cycles: 4 cycles per digit, 4 digits.
    always @(negedge clk) begin
        if (cmp_en) begin
            int idx, pw;
            logic [6:0] exp_seg;
            idx = (m_cyc / 4) % 4;
            pw  = 10 ** idx;
            exp_seg = (idx > 0 && m_prev < pw) ? 7'b0 : seg_tab[(m_prev / pw) % 10];
            checkOutput("model_dig_sel", 32'(dig_sel), 32'(~(4'b0001 << idx) & 4'hF));
            checkOutput("model_seg", 32'(seg), 32'(exp_seg));
            checkOutput("model_mode", 32'(mode), 32'(m_mode));
            checkOutput("model_co", 32'(co), 32'(m_co));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Get into a non-reset state, then reset asynchronously in the middle of a slot.
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre_reset_mode_run", 32'(mode), 32'd1);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        pulse_reset();

        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
        wait_slot(4'b1110, "val12_units", 7'b1101101);
        wait_slot(4'b1101, "val12_tens", 7'b0110000);
        wait_slot(4'b1011, "val12_d2_blank", 7'b0000000);
        wait_slot(4'b0111, "val12_d3_blank", 7'b0000000);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            applyStimulus(r < 40, r >= 30 && r < 70, r >= 96);
        end

        pulse_reset();
        repeat (9999) applyStimulus(1'b1, 1'b0, 1'b0);
        wait_slot(4'b0111, "val9999_d3", 7'b1111011);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("wrap_co_high", 32'(co), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wrap_co_one_cycle", 32'(co), 32'd0);
        wait_slot(4'b1110, "wrap_units", 7'b1111110);
        wait_slot(4'b1101, "wrap_tens_blank", 7'b0000000);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("borrow_co_low", 32'(co), 32'd0);
        wait_slot(4'b0111, "borrow_d3", 7'b1111011);

        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_slot(4'b1110, "both_keys_units", 7'b1011011);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("mode_wins_run", 32'(mode), 32'd1);

        repeat (64) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mode_pause", 32'(mode), 32'd2);
        repeat (100) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        wait_slot(4'b1110, "run_result_units", 7'b1111011);
        wait_slot(4'b1101, "run_result_tens_blank", 7'b0000000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("mode_manual", 32'(mode), 32'd0);

        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
